lock_code_programmer: RTL and testbench

LOCK_CODE_PROGRAMMER -- requirements
Module: lock_code_programmer

---
 rtl/lock_code_programmer_pkg.sv | 22 ++
 rtl/lock_code_programmer_vdff.sv | 14 +
 rtl/lock_code_programmer.sv | 151 +++++++++++++++
 tb/tb_lock_code_programmer.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/lock_code_programmer_pkg.sv
// Shared definitions for the lock programmer and lock checker:
// FSM state encodings, status encodings, digit count and factory combination.
package lock_code_programmer_pkg;

  localparam int unsigned LCP_NDIG         = 6;
  localparam int unsigned LCP_STATE_W      = 3;
  localparam logic [23:0] LCP_DEFAULT_CODE = 24'h369561;

  typedef enum logic [LCP_STATE_W-1:0] {
    ST_IDLE     = 3'd0,
    ST_ENTER1   = 3'd1,
    ST_ENTER2   = 3'd2,
    ST_DONE_OK  = 3'd3,
    ST_DONE_ERR = 3'd4
  } state_t;

  localparam logic [1:0] STATUS_OPEN    = 2'b00;
  localparam logic [1:0] STATUS_CLOSED  = 2'b01;
  localparam logic [1:0] STATUS_ILLEGAL = 2'b10;
  localparam logic [1:0] STATUS_LEGAL   = 2'b11;

endpackage

// File: rtl/lock_code_programmer_vdff.sv
// Plain W-bit D flip-flop bank; any reset is muxed onto d by the caller.
module lock_code_programmer_vdff #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    q <= d;
  end

endmodule

// File: rtl/lock_code_programmer.sv
// Two-pass combination programmer: digits are entered, then re-entered to
// confirm, and only a matching confirmation is committed to code.
module lock_code_programmer
  import lock_code_programmer_pkg::*;
#(
  parameter int unsigned         NDIG         = LCP_NDIG,
  parameter logic [4*NDIG-1:0]   DEFAULT_CODE = (4*NDIG)'(LCP_DEFAULT_CODE)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        in,
  input  logic              enter,
  input  logic              prog,
  output logic [4*NDIG-1:0] code,
  output logic              code_new,
  output logic [1:0]        status,
  output logic [2:0]        pos,
  output logic              busy
);

  localparam int unsigned CW = 4 * NDIG;
  localparam int unsigned PW = 3;

  state_t               state;
  state_t               state_nx;
  logic [LCP_STATE_W-1:0] state_d;
  logic [LCP_STATE_W-1:0] state_q;

  logic [CW-1:0] shadow;
  logic [CW-1:0] shadow_nx;
  logic [CW-1:0] code_nx;
  logic [PW-1:0] pos_nx;
  logic [1:0]    status_nx;
  logic          mism;
  logic          mism_nx;
  logic          mism_all;
  logic          code_new_nx;
  logic          busy_nx;
  logic          digit_ok;
  logic          last;
  logic [3:0]    cur;

  // State register; synchronous reset is applied on the D side.
  assign state_d = reset ? LCP_STATE_W'(ST_IDLE) : LCP_STATE_W'(state_nx);
  assign state   = state_t'(state_q);

  lock_code_programmer_vdff #(.W(LCP_STATE_W)) u_state (
    .clk (clk),
    .d   (state_d),
    .q   (state_q)
  );

  always_comb begin
    state_nx    = state;
    code_nx     = code;
    shadow_nx   = shadow;
    pos_nx      = pos;
    status_nx   = status;
    mism_nx     = mism;
    code_new_nx = 1'b0;
    digit_ok    = (in <= 4'd9);
    last        = (pos == PW'(NDIG - 1));
    cur         = '0;
    for (int k = 0; k < int'(NDIG); k++) begin
      if (pos == PW'(k)) cur = shadow[4*(int'(NDIG)-k)-1 -: 4];
    end
    mism_all = mism | (in != cur);

    unique case (state)
      ST_IDLE: begin
        if (prog) begin
          state_nx = ST_ENTER1;
          pos_nx   = '0;
          mism_nx  = 1'b0;
        end
      end
      ST_ENTER1, ST_ENTER2: begin
        // Dropping prog aborts the pass; a same-cycle enter is discarded.
        if (!prog) begin
          state_nx  = ST_IDLE;
          pos_nx    = '0;
          status_nx = STATUS_LEGAL;
        end else if (enter) begin
          if (!digit_ok) begin
            status_nx = STATUS_ILLEGAL;
          end else begin
            status_nx = STATUS_LEGAL;
            pos_nx    = pos + PW'(1);
            if (state == ST_ENTER1) begin
              for (int k = 0; k < int'(NDIG); k++) begin
                if (pos == PW'(k)) shadow_nx[4*(int'(NDIG)-k)-1 -: 4] = in;
              end
              if (last) begin
                state_nx = ST_ENTER2;
                pos_nx   = '0;
              end
            end else begin
              mism_nx = mism_all;
              if (last) begin
                pos_nx = '0;
                if (!mism_all) begin
                  state_nx    = ST_DONE_OK;
                  status_nx   = STATUS_OPEN;
                  code_nx     = shadow;
                  code_new_nx = 1'b1;
                end else begin
                  state_nx  = ST_DONE_ERR;
                  status_nx = STATUS_CLOSED;
                end
              end
            end
          end
        end
      end
      ST_DONE_OK, ST_DONE_ERR: begin
        if (!prog) begin
          state_nx  = ST_IDLE;
          status_nx = STATUS_LEGAL;
        end
      end
      default: begin
        state_nx  = ST_IDLE;
        pos_nx    = '0;
        status_nx = STATUS_LEGAL;
      end
    endcase

    busy_nx = (state_nx == ST_ENTER1) || (state_nx == ST_ENTER2);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      code     <= DEFAULT_CODE;
      code_new <= 1'b0;
      status   <= STATUS_LEGAL;
      pos      <= '0;
      busy     <= 1'b0;
      shadow   <= '0;
      mism     <= 1'b0;
    end else begin
      code     <= code_nx;
      code_new <= code_new_nx;
      status   <= status_nx;
      pos      <= pos_nx;
      busy     <= busy_nx;
      shadow   <= shadow_nx;
      mism     <= mism_nx;
    end
  end

endmodule

// File: tb/tb_lock_code_programmer.sv
// Bench for lock_code_programmer: directed scenarios against fixed values,
// then random traffic against a digit-array reference model.
module tb_lock_code_programmer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  in = '0;
  logic        enter = 1'b0;
  logic        prog = 1'b0;
  logic [23:0] code;
  logic        code_new;
  logic [1:0]  status;
  logic [2:0]  pos;
  logic        busy;

  int checks = 0;
  int errors = 0;

  // Reference model: mode 0 idle, 1 first pass, 2 confirm, 3 ok, 4 error.
  int m_mode;
  int m_code[6];
  int m_shadow[6];
  int m_cnt;
  bit m_bad;
  bit m_pulse;
  int m_status;

  lock_code_programmer dut (
    .clk      (clk),
    .reset    (reset),
    .in       (in),
    .enter    (enter),
    .prog     (prog),
    .code     (code),
    .code_new (code_new),
    .status   (status),
    .pos      (pos),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] m_code_vec();
    logic [23:0] v;
    v = '0;
    for (int k = 0; k < 6; k++) v[4*(6-k)-1 -: 4] = 4'(m_code[k]);
    return v;
  endfunction

  task automatic model_step(input bit r, input int d, input bit e, input bit p);
    int def[6];
    def = '{3, 6, 9, 5, 6, 1};
    m_pulse = 1'b0;
    if (r) begin
      m_mode = 0; m_cnt = 0; m_bad = 1'b0; m_status = 3;
      for (int k = 0; k < 6; k++) begin m_code[k] = def[k]; m_shadow[k] = 0; end
    end else if (m_mode == 0) begin
      if (p) begin m_mode = 1; m_cnt = 0; m_bad = 1'b0; end
    end else if (m_mode == 1 || m_mode == 2) begin
      if (!p) begin
        m_mode = 0; m_cnt = 0; m_status = 3;
      end else if (e) begin
        if (d > 9) begin
          m_status = 2;
        end else begin
          m_status = 3;
          if (m_mode == 1) m_shadow[m_cnt] = d;
          else if (d != m_shadow[m_cnt]) m_bad = 1'b1;
          if (m_cnt == 5) begin
            m_cnt = 0;
            if (m_mode == 1) m_mode = 2;
            else if (!m_bad) begin
              m_mode = 3; m_status = 0; m_pulse = 1'b1;
              for (int k = 0; k < 6; k++) m_code[k] = m_shadow[k];
            end else begin
              m_mode = 4; m_status = 1;
            end
          end else begin
            m_cnt++;
          end
        end
      end
    end else begin
      if (!p) begin m_mode = 0; m_status = 3; end
    end
  endtask

  task automatic cycle(input bit r, input int d, input bit e, input bit p);
    reset = r; in = 4'(d); enter = e; prog = p;
    @(posedge clk);
    model_step(r, d, e, p);
    #1;
  endtask

  task automatic enter_seq(input int d[6]);
    for (int k = 0; k < 6; k++) cycle(1'b0, d[k], 1'b1, 1'b1);
  endtask

  task automatic test_reset();
    cycle(1'b1, 0, 1'b0, 1'b0);
    cycle(1'b1, 5, 1'b1, 1'b1);
    checks++; if (code !== 24'h369561) begin errors++; $display("FAIL reset_code got %h exp 369561", code); end
    checks++; if (status !== 2'b11) begin errors++; $display("FAIL reset_status got %b exp 11", status); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (code_new !== 1'b0) begin errors++; $display("FAIL reset_code_new got %b exp 0", code_new); end
    checks++; if (pos !== 3'd0) begin errors++; $display("FAIL reset_pos got %0d exp 0", pos); end
    cycle(1'b0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_program_ok();
    cycle(1'b0, 0, 1'b0, 1'b1);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ok_busy got %b exp 1", busy); end
    enter_seq('{1, 2, 3, 4, 5, 6});
    checks++; if (pos !== 3'd0 || busy !== 1'b1) begin errors++; $display("FAIL ok_enter2 pos %0d busy %b exp 0 1", pos, busy); end
    enter_seq('{1, 2, 3, 4, 5, 6});
    checks++; if (status !== 2'b00) begin errors++; $display("FAIL ok_status got %b exp 00", status); end
    checks++; if (code !== 24'h123456) begin errors++; $display("FAIL ok_code got %h exp 123456", code); end
    checks++; if (code_new !== 1'b1) begin errors++; $display("FAIL ok_code_new got %b exp 1", code_new); end
    cycle(1'b0, 0, 1'b0, 1'b1);
    checks++; if (code_new !== 1'b0) begin errors++; $display("FAIL ok_code_new_pulse got %b exp 0", code_new); end
    cycle(1'b0, 0, 1'b0, 1'b0);
    checks++; if (status !== 2'b11 || busy !== 1'b0) begin errors++; $display("FAIL ok_idle status %b busy %b exp 11 0", status, busy); end
  endtask

  task automatic test_program_err();
    cycle(1'b0, 0, 1'b0, 1'b1);
    enter_seq('{1, 2, 3, 4, 5, 6});
    enter_seq('{1, 2, 3, 4, 5, 7});
    checks++; if (status !== 2'b01) begin errors++; $display("FAIL err_status got %b exp 01", status); end
    checks++; if (code !== 24'h123456) begin errors++; $display("FAIL err_code got %h exp 123456", code); end
    checks++; if (code_new !== 1'b0) begin errors++; $display("FAIL err_code_new got %b exp 0", code_new); end
    cycle(1'b0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_illegal();
    cycle(1'b0, 0, 1'b0, 1'b1);
    cycle(1'b0, 1, 1'b1, 1'b1);
    cycle(1'b0, 2, 1'b1, 1'b1);
    cycle(1'b0, 11, 1'b1, 1'b1);
    checks++; if (status !== 2'b10 || pos !== 3'd2) begin errors++; $display("FAIL illegal status %b pos %0d exp 10 2", status, pos); end
    cycle(1'b0, 0, 1'b0, 1'b1);
    checks++; if (status !== 2'b10 || pos !== 3'd2) begin errors++; $display("FAIL illegal_hold status %b pos %0d exp 10 2", status, pos); end
    cycle(1'b0, 3, 1'b1, 1'b1);
    checks++; if (status !== 2'b11 || pos !== 3'd3) begin errors++; $display("FAIL illegal_recover status %b pos %0d exp 11 3", status, pos); end
    cycle(1'b0, 0, 1'b0, 1'b0);
    checks++; if (pos !== 3'd0 || busy !== 1'b0) begin errors++; $display("FAIL illegal_abort pos %0d busy %b exp 0 0", pos, busy); end
  endtask

  task automatic test_abort_and_reset();
    cycle(1'b0, 0, 1'b0, 1'b1);
    enter_seq('{9, 8, 7, 6, 5, 4});
    cycle(1'b0, 9, 1'b1, 1'b1);
    cycle(1'b0, 8, 1'b1, 1'b1);
    checks++; if (pos !== 3'd2 || busy !== 1'b1) begin errors++; $display("FAIL abort_pre pos %0d busy %b exp 2 1", pos, busy); end
    cycle(1'b0, 7, 1'b1, 1'b0);
    checks++; if (pos !== 3'd0 || busy !== 1'b0 || code !== 24'h123456) begin
      errors++; $display("FAIL abort pos %0d busy %b code %h exp 0 0 123456", pos, busy, code);
    end
    cycle(1'b0, 0, 1'b0, 1'b1);
    enter_seq('{4, 4, 4, 4, 4, 4});
    cycle(1'b0, 4, 1'b1, 1'b1);
    cycle(1'b1, 4, 1'b1, 1'b1);
    checks++; if (code !== 24'h369561 || pos !== 3'd0 || busy !== 1'b0 || status !== 2'b11) begin
      errors++; $display("FAIL mid_reset code %h pos %0d busy %b status %b exp 369561 0 0 11", code, pos, busy, status);
    end
    cycle(1'b0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_idle_enter();
    cycle(1'b0, 7, 1'b1, 1'b0);
    cycle(1'b0, 2, 1'b1, 1'b0);
    checks++; if (code !== 24'h369561 || pos !== 3'd0 || busy !== 1'b0) begin
      errors++; $display("FAIL idle_enter code %h pos %0d busy %b exp 369561 0 0", code, pos, busy);
    end
    cycle(1'b0, 0, 1'b0, 1'b1);
    enter_seq('{0, 9, 0, 9, 0, 9});
    enter_seq('{0, 9, 0, 9, 0, 9});
    for (int k = 0; k < 3; k++) cycle(1'b0, 5, 1'b1, 1'b1);
    checks++; if (code !== 24'h090909 || pos !== 3'd0 || busy !== 1'b0 || status !== 2'b00 || code_new !== 1'b0) begin
      errors++; $display("FAIL done_enter code %h pos %0d busy %b status %b new %b exp 090909 0 0 00 0", code, pos, busy, status, code_new);
    end
    cycle(1'b0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    int d;
    bit e, p, r;
    for (int c = 0; c < 1500; c++) begin
      r = ($urandom_range(0, 299) == 0);
      e = ($urandom_range(0, 1) == 1);
      if (m_mode == 2 && $urandom_range(0, 7) != 0) d = m_shadow[m_cnt];
      else if ($urandom_range(0, 5) == 0) d = $urandom_range(10, 15);
      else d = $urandom_range(0, 9);
      if (m_mode == 1 || m_mode == 2) p = ($urandom_range(0, 59) != 0);
      else if (m_mode == 0) p = ($urandom_range(0, 3) != 0);
      else p = ($urandom_range(0, 3) != 0);
      cycle(r, d, e, p);
      checks++; if (code !== m_code_vec()) begin errors++; $display("FAIL rand_code cyc %0d got %h exp %h", c, code, m_code_vec()); end
      checks++; if (code_new !== m_pulse) begin errors++; $display("FAIL rand_code_new cyc %0d got %b exp %b", c, code_new, m_pulse); end
      checks++; if (status !== 2'(m_status)) begin errors++; $display("FAIL rand_status cyc %0d got %b exp %b", c, status, 2'(m_status)); end
      checks++; if (pos !== 3'(m_cnt)) begin errors++; $display("FAIL rand_pos cyc %0d got %0d exp %0d", c, pos, m_cnt); end
      checks++; if (busy !== (m_mode == 1 || m_mode == 2)) begin
        errors++; $display("FAIL rand_busy cyc %0d got %b exp %b", c, busy, (m_mode == 1 || m_mode == 2));
      end
    end
  endtask

  initial begin
    m_mode = 0; m_cnt = 0; m_bad = 1'b0; m_pulse = 1'b0; m_status = 3;
    for (int k = 0; k < 6; k++) begin m_code[k] = 0; m_shadow[k] = 0; end
    test_reset();
    test_program_ok();
    test_program_err();
    test_illegal();
    test_abort_and_reset();
    test_idle_enter();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
